alu_pipelined_unit: RTL and testbench

//  Parametrised, handshaked successor to the single-cycle ALU_Unit datapath ALU.

---
 rtl/alu_pkg.sv | 28 ++
 rtl/alu_iter_muldiv.sv | 93 +++++++++
 rtl/alu_pipelined_unit.sv | 141 ++++++++++++++
 tb/tb_alu_pipelined_unit.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode encodings and FSM state type for the pipelined ALU.
package alu_pkg;

    localparam int unsigned OPW = 4;

    localparam logic [OPW-1:0] OP_ADD  = 4'b0000;
    localparam logic [OPW-1:0] OP_SUB  = 4'b0001;
    localparam logic [OPW-1:0] OP_SLL  = 4'b0010;
    localparam logic [OPW-1:0] OP_AND  = 4'b0011;
    localparam logic [OPW-1:0] OP_OR   = 4'b0100;
    localparam logic [OPW-1:0] OP_XOR  = 4'b0101;
    localparam logic [OPW-1:0] OP_SRL  = 4'b0110;
    localparam logic [OPW-1:0] OP_SLT  = 4'b0111;
    localparam logic [OPW-1:0] OP_MUL  = 4'b1000;
    localparam logic [OPW-1:0] OP_DIVU = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Opcodes that run on the iterative engine instead of the single-cycle datapath
    function automatic logic is_iter_op(input logic [OPW-1:0] op);
        return (op == OP_MUL) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative engine: shift-add multiply (LSB first) and restoring unsigned divide (MSB first).
// One step per cycle for exactly WIDTH cycles after start; done_c flags the final step.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CNTW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done_c,
    output logic [WIDTH-1:0] result_c
);

    // acc: product accumulator / partial remainder
    // aux: shifted multiplicand / divisor
    // shf: multiplier shifted right / dividend shifting out while quotient shifts in
    logic             div_q,    div_d;
    logic             active_q, active_d;
    logic [CNTW-1:0]  cnt_q,    cnt_d;
    logic [WIDTH-1:0] acc_q,    acc_d;
    logic [WIDTH-1:0] aux_q,    aux_d;
    logic [WIDTH-1:0] shf_q,    shf_d;
    logic [WIDTH:0]   rem_sh;

    // Next-state for one iteration step or a fresh start
    always_comb begin
        div_d    = div_q;
        active_d = active_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        aux_d    = aux_q;
        shf_d    = shf_q;
        rem_sh   = {acc_q, shf_q[WIDTH-1]};

        if (start) begin
            div_d    = is_div;
            active_d = 1'b1;
            cnt_d    = CNTW'(WIDTH - 1);
            acc_d    = '0;
            aux_d    = is_div ? op_b : op_a;
            shf_d    = is_div ? op_a : op_b;
        end else if (active_q) begin
            if (div_q) begin
                if (rem_sh >= {1'b0, aux_q}) begin
                    acc_d = WIDTH'(rem_sh - {1'b0, aux_q});
                    shf_d = {shf_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_sh[WIDTH-1:0];
                    shf_d = {shf_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                if (shf_q[0]) begin
                    acc_d = acc_q + aux_q;
                end
                aux_d = aux_q << 1;
                shf_d = shf_q >> 1;
            end
            if (cnt_q == '0) begin
                active_d = 1'b0;
            end else begin
                cnt_d = cnt_q - CNTW'(1);
            end
        end
    end

    // Engine state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= 1'b0;
            active_q <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            aux_q    <= '0;
            shf_q    <= '0;
        end else begin
            div_q    <= div_d;
            active_q <= active_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            aux_q    <= aux_d;
            shf_q    <= shf_d;
        end
    end

    assign done_c   = active_q && (cnt_q == '0);
    assign result_c = div_q ? shf_q : acc_q;

endmodule

// File: rtl/alu_pipelined_unit.sv
// Handshaked ALU: captures operands on accept, computes single-cycle ops directly or
// via the iterative engine, and holds a registered result until the consumer takes it.
module alu_pipelined_unit
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned SHW   = 4,
    parameter int unsigned CNTW  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] ALU_InA,
    input  logic [WIDTH-1:0] ALU_InB,
    input  logic [OPW-1:0]   ALU_cont,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALU_output,
    output logic             ALU_zero,
    output logic             ALU_busy
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] cap_a_q, cap_a_d;
    logic [WIDTH-1:0] cap_b_q, cap_b_d;
    logic [OPW-1:0]   cap_op_q, cap_op_d;
    logic             out_valid_d, in_ready_d, busy_d, zero_d;
    logic [WIDTH-1:0] out_d;
    logic             start_c;
    logic             eng_done_c;
    logic [WIDTH-1:0] eng_result_c;
    logic [WIDTH-1:0] res_c;
    logic [SHW-1:0]   sh_c;

    alu_iter_muldiv #(
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_c),
        .is_div   (ALU_cont == OP_DIVU),
        .op_a     (ALU_InA),
        .op_b     (ALU_InB),
        .done_c   (eng_done_c),
        .result_c (eng_result_c)
    );

    // Result select from captured operands (iterative ops read the engine)
    always_comb begin
        sh_c  = cap_a_q[SHW-1:0];
        res_c = '0;
        case (cap_op_q)
            OP_ADD:  res_c = cap_a_q + cap_b_q;
            OP_SUB:  res_c = cap_a_q - cap_b_q;
            OP_SLL:  res_c = cap_b_q << sh_c;
            OP_AND:  res_c = cap_a_q & cap_b_q;
            OP_OR:   res_c = cap_a_q | cap_b_q;
            OP_XOR:  res_c = cap_a_q ^ cap_b_q;
            OP_SRL:  res_c = cap_b_q >> sh_c;
            OP_SLT:  res_c = {{(WIDTH-1){1'b0}}, ($signed(cap_a_q) < $signed(cap_b_q))};
            OP_MUL,
            OP_DIVU: res_c = eng_result_c;
            default: res_c = '0;
        endcase
    end

    // FSM next-state and next values of all registered outputs
    always_comb begin
        state_d     = state_q;
        cap_a_d     = cap_a_q;
        cap_b_d     = cap_b_q;
        cap_op_d    = cap_op_q;
        out_valid_d = out_valid;
        out_d       = ALU_output;
        zero_d      = ALU_zero;
        start_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    cap_a_d  = ALU_InA;
                    cap_b_d  = ALU_InB;
                    cap_op_d = ALU_cont;
                    if (is_iter_op(ALU_cont)) begin
                        start_c = 1'b1;
                        state_d = EXEC;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            EXEC: begin
                if (eng_done_c) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!out_valid) begin
                    out_valid_d = 1'b1;
                    out_d       = res_c;
                    zero_d      = (res_c == '0);
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE);
        busy_d     = (state_d == EXEC);
    end

    // State, capture and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cap_a_q    <= '0;
            cap_b_q    <= '0;
            cap_op_q   <= '0;
            out_valid  <= 1'b0;
            ALU_output <= '0;
            ALU_zero   <= 1'b0;
            ALU_busy   <= 1'b0;
            in_ready   <= 1'b1;
        end else begin
            state_q    <= state_d;
            cap_a_q    <= cap_a_d;
            cap_b_q    <= cap_b_d;
            cap_op_q   <= cap_op_d;
            out_valid  <= out_valid_d;
            ALU_output <= out_d;
            ALU_zero   <= zero_d;
            ALU_busy   <= busy_d;
            in_ready   <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_alu_pipelined_unit.sv
// Directed bench for alu_pipelined_unit with an expected-result queue.
module tb_alu_pipelined_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] ALU_InA;
    logic [15:0] ALU_InB;
    logic [3:0]  ALU_cont;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] ALU_output;
    logic        ALU_zero;
    logic        ALU_busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    alu_pipelined_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ALU_InA    (ALU_InA),
        .ALU_InB    (ALU_InB),
        .ALU_cont   (ALU_cont),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .ALU_output (ALU_output),
        .ALU_zero   (ALU_zero),
        .ALU_busy   (ALU_busy)
    );

    always #5 clk = ~clk;

    // Reference model of the operation set
    function automatic logic [15:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [31:0] p;
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return b << a[3:0];
            4'd3: return a & b;
            4'd4: return a | b;
            4'd5: return a ^ b;
            4'd6: return b >> a[3:0];
            4'd7: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            4'd8: begin p = {16'd0, a} * {16'd0, b}; return p[15:0]; end
            4'd9: return (b == 16'd0) ? 16'hFFFF : a / b;
            default: return 16'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one op with out_ready high, check result, latency, busy and in_ready profile
    task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int k, n_busy, n_low;
        logic [15:0] e;
        bit iter;
        iter = (op == 4'd8) || (op == 4'd9);
        exp_q.push_back(model(op, a, b));
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1);
        in_valid  = 1'b1;
        ALU_cont  = op;
        ALU_InA   = a;
        ALU_InB   = b;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        ALU_InA  = 16'($urandom);
        ALU_InB  = 16'($urandom);
        ALU_cont = 4'($urandom);
        k = 0; n_busy = 0; n_low = 0;
        while (!out_valid && k < 100) begin
            n_busy += int'(ALU_busy);
            n_low  += int'(!in_ready);
            @(posedge clk); #1;
            k++;
        end
        chk({tag, "_latency"}, k, iter ? 17 : 1);
        chk({tag, "_busy_cycles"}, n_busy, iter ? 16 : 0);
        chk({tag, "_ready_low"}, n_low, k);
        e = exp_q.pop_front();
        chk({tag, "_result"}, ALU_output, e);
        chk({tag, "_zero"}, ALU_zero, (e == 16'd0));
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, out_valid, 0);
        chk({tag, "_ready_back"}, in_ready, 1);
    endtask

    initial begin
        logic [15:0] e;
        int k;
        bit seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ALU_InA = '0; ALU_InB = '0; ALU_cont = '0;
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_output", ALU_output, 0);
        chk("rst_zero", ALU_zero, 0);
        chk("rst_busy", ALU_busy, 0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", in_ready, 1);

        run_op("add", 4'd0, 16'd5, 16'd3);
        run_op("sub", 4'd1, 16'd5, 16'd3);
        run_op("sll", 4'd2, 16'd3, 16'h000F);
        run_op("and", 4'd3, 16'hAAAA, 16'h5555);
        run_op("mul", 4'd8, 16'd300, 16'd200);
        run_op("divu", 4'd9, 16'd100, 16'd7);
        run_op("divu0", 4'd9, 16'd5, 16'd0);
        run_op("slt", 4'd7, 16'hFFFF, 16'd1);
        run_op("srl", 4'd6, 16'd4, 16'h8000);
        run_op("op15", 4'd15, 16'h1234, 16'h5678);
        run_op("or", 4'd4, 16'hF000, 16'h000F);
        run_op("xor", 4'd5, 16'hFFFF, 16'hFFFF);
        run_op("mul_wrap", 4'd8, 16'hFFFF, 16'hFFFF);
        run_op("divu_big", 4'd9, 16'hFFFF, 16'd1);
        for (int i = 0; i < 8; i++) begin
            run_op("rand", 4'($urandom_range(0, 15)), 16'($urandom), 16'($urandom));
        end

        // Backpressure: result held 5 cycles, new requests ignored
        exp_q.push_back(model(4'd0, 16'h1234, 16'h0101));
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1;
        ALU_cont = 4'd0; ALU_InA = 16'h1234; ALU_InB = 16'h0101;
        @(posedge clk); #1;
        in_valid = 1'b0;
        k = 0;
        while (!out_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        chk("bp_latency", k, 1);
        e = exp_q.pop_front();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; ALU_cont = 4'd1; ALU_InA = 16'($urandom); ALU_InB = 16'($urandom);
            @(posedge clk); #1;
            chk("bp_valid", out_valid, 1);
            chk("bp_output", ALU_output, e);
            chk("bp_zero", ALU_zero, 0);
            chk("bp_in_ready", in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_valid_drop", out_valid, 0);
        chk("bp_ready_back", in_ready, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("bp_no_stray", out_valid, 0);

        // Reset in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1; ALU_cont = 4'd8; ALU_InA = 16'd300; ALU_InB = 16'd200;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_output", ALU_output, 0);
        chk("midrst_zero", ALU_zero, 0);
        chk("midrst_busy", ALU_busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("midrst_in_ready", in_ready, 1);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            seen |= out_valid;
        end
        chk("midrst_no_output", seen, 0);
        run_op("post_rst_add", 4'd0, 16'd40, 16'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
